four_bit_shift_circuit: RTL and testbench

FOUR_BIT_SHIFT_CIRCUIT -- requirements
Module: four_bit_shift_circuit

---
 rtl/shift_pkg.sv | 12 +
 rtl/shift_unit.sv | 35 +++
 rtl/four_bit_shift_circuit.sv | 37 +++
 tb/tb_four_bit_shift_circuit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the four-bit shift circuit: default data width and
// the direction encoding carried on right_shift.
package shift_pkg;

    localparam int SHIFT_WIDTH = 4;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

endpackage : shift_pkg

// File: rtl/shift_unit.sv
// Combinational one-bit shifter. Logical shift by default; defining ROTATE_EN
// turns it into a one-bit rotate (the bit shifted out becomes the fill bit).
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] operand_i,
    input  shift_dir_e       dir_i,
    output logic [WIDTH-1:0] result_o
);

    logic fill;

    always_comb begin
        fill     = 1'b0;
        result_o = '0;
        if (dir_i == SHIFT_RIGHT) begin
`ifdef ROTATE_EN
            fill = operand_i[0];
`else
            fill = 1'b0;
`endif
            result_o = {fill, operand_i[WIDTH-1:1]};
        end else begin
`ifdef ROTATE_EN
            fill = operand_i[WIDTH-1];
`else
            fill = 1'b0;
`endif
            result_o = {operand_i[WIDTH-2:0], fill};
        end
    end

endmodule : shift_unit

// File: rtl/four_bit_shift_circuit.sv
// Registered one-bit shifter: data_out is loaded every clock with data_in
// shifted toward right_shift's direction. Fill behaviour set by ROTATE_EN.
module four_bit_shift_circuit
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             right_shift,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift_unit (
        .operand_i (data_in),
        .dir_i     (shift_dir_e'(right_shift)),
        .result_o  (data_d)
    );

    // No enable: the register reloads on every edge outside reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule : four_bit_shift_circuit

// File: tb/tb_four_bit_shift_circuit.sv
// Self-checking bench for four_bit_shift_circuit; expectations follow ROTATE_EN
// when the bench is compiled with the same macro as the design.
module tb_four_bit_shift_circuit;

`ifdef ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clock;
    logic       clk_en;
    logic       reset;
    logic       right_shift;
    logic [3:0] data_in;
    logic [3:0] data_out;

    int checks;
    int failures;

    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] din;
        logic       rs;
        logic [3:0] exp_plain;
        logic [3:0] exp_rot;
    } vec_t;

    vec_t vecs[10];

    four_bit_shift_circuit #(
        .WIDTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .right_shift (right_shift),
        .data_in     (data_in),
        .data_out    (data_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever begin
            #5;
            if (clk_en) clock = ~clock;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model / checking ----------------
    function automatic logic [3:0] model(input logic [3:0] d, input logic rs);
        logic [3:0] r;
        if (rs) begin
            r = d >> 1;
            if (ROT && d[0]) r = r + 4'd8;
        end else begin
            r = (d << 1) & 4'hF;
            if (ROT && d[3]) r = r + 4'd1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: act=%b req=%b", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] din, input logic rs, input logic [3:0] exp);
        @(negedge clock);
        data_in     = din;
        right_shift = rs;
        exp_q.push_back(exp);
    endtask

    task automatic collect(input string name);
        logic [3:0] e;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: act=empty_queue req=entry", name);
        end else begin
            e = exp_q.pop_front();
            check(name, data_out, e);
        end
    endtask

    task automatic apply(input string name, input logic [3:0] din, input logic rs,
                         input logic [3:0] exp);
        drive(din, rs, exp);
        collect(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks      = 0;
        failures    = 0;
        clk_en      = 1'b1;
        reset       = 1'b1;
        right_shift = 1'b0;
        data_in     = 4'b1111;

        vecs[0] = '{4'b0101, 1'b0, 4'b1010, 4'b1010};
        vecs[1] = '{4'b0011, 1'b0, 4'b0110, 4'b0110};
        vecs[2] = '{4'b1010, 1'b1, 4'b0101, 4'b0101};
        vecs[3] = '{4'b1100, 1'b1, 4'b0110, 4'b0110};
        vecs[4] = '{4'b1001, 1'b0, 4'b0010, 4'b0011};
        vecs[5] = '{4'b0001, 1'b1, 4'b0000, 4'b1000};
        vecs[6] = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[7] = '{4'b0000, 1'b1, 4'b0000, 4'b0000};
        vecs[8] = '{4'b1111, 1'b0, 4'b1110, 4'b1111};
        vecs[9] = '{4'b1111, 1'b1, 4'b0111, 4'b1111};

        // Reset held with a live clock and all-ones input: output stays zero.
        #1;
        check("reset_initial", data_out, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("reset_held_edge", data_out, 4'b0000);
        end

        // First edge after reset release performs a normal load.
        @(negedge clock);
        reset = 1'b0;
        apply("first_after_reset", 4'b0101, 1'b0, 4'b1010);

        // Directed table.
        foreach (vecs[i]) begin
            apply($sformatf("table_%0d", i), vecs[i].din, vecs[i].rs,
                  ROT ? vecs[i].exp_rot : vecs[i].exp_plain);
        end

        // Direction change: new select only takes effect at the next edge.
        apply("dir_right_1111", 4'b1111, 1'b1, model(4'b1111, 1'b1));
        drive(4'b0001, 1'b0, 4'b0010);
        #1;
        check("hold_after_change", data_out, ROT ? 4'b1111 : 4'b0111);
        #3;
        check("hold_before_edge", data_out, ROT ? 4'b1111 : 4'b0111);
        collect("dir_left_0001");

        // Asynchronous reset with the clock stopped.
        apply("preload_1010", 4'b0101, 1'b0, 4'b1010);
        @(negedge clock);
        clk_en = 1'b0;
        #2;
        check("stopped_hold", data_out, 4'b1010);
        reset = 1'b1;
        #1;
        check("async_reset", data_out, 4'b0000);
        #20;
        check("async_reset_stays", data_out, 4'b0000);
        reset  = 1'b0;
        clk_en = 1'b1;
        apply("load_after_async", 4'b0011, 1'b0, 4'b0110);

        // Reset raised mid-operation with the clock running.
        apply("preload_mid", 4'b1100, 1'b1, 4'b0110);
        @(negedge clock);
        data_in = 4'b1111;
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_now", data_out, 4'b0000);
        @(posedge clock);
        #1;
        check("mid_reset_edge", data_out, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        apply("mid_reset_release", 4'b1001, 1'b1, model(4'b1001, 1'b1));

        // Random vectors, back-to-back through the scoreboard.
        for (int i = 0; i < 24; i++) begin
            logic [3:0] d;
            logic       r;
            d = 4'($urandom_range(0, 15));
            r = 1'($urandom_range(0, 1));
            apply("random", d, r, model(d, r));
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain: act=%0d req=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_four_bit_shift_circuit
